alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered ALU operand-select stage for the pipelined WISC core; sits between decode/register-file read and execute.
- Generalises the single-cycle source mux in three ways:
  - parametrised data and immediate widths;
  - four immediate-extension modes;
  - EX/MEM forwarding on both operands.
- Adds a valid/ready pipeline register with stall/flush and a saturating forwarding-event counter for performance debug.

Parameters:
- DATA_W, 16, operand width in bits; must satisfy DATA_W > IMM_W.
- IMM_W, 8, immediate field width in bits.
- REG_AW, 4, register address width; address 0 is hardwired zero and is never forwarded.
- CNT_W, 16, width of the forwarding-event counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an operand set.
- in_ready  out  1  stage can accept the operand set this cycle.
- rf_p0 / rf_p1  in  DATA_W  register-file read data.
- rf_a0 / rf_a1  in  REG_AW  source register addresses.
- imm  in  IMM_W  immediate field.
- imm_mode  in  2  00 sign-extend, 01 zero-extend, 10 upper, 11 upper-merge.
- src1_sel  in  1  1 = register operand, 0 = immediate operand.
- ex_we, ex_wa, ex_wd  in  1/REG_AW/DATA_W  EX-stage result being written.
- mem_we, mem_wa, mem_wd  in  1/REG_AW/DATA_W  MEM-stage result being written.
- flush  in  1  kills the held entry and the incoming entry.
- out_valid  out  1  src0/src1 are valid.
- out_ready  in  1  execute consumes the operands.
- src0 / src1  out  DATA_W  registered ALU operands.
- fwd_cnt  out  CNT_W  saturating count of forwarded operands.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, src0=0, src1=0, fwd_cnt=0. in_ready is 1 immediately, because it is combinational from out_valid.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Transfer occurs when in_valid & in_ready.
  - On transfer, src0/src1 load next cycle and out_valid=1: latency 1 cycle.
  - Held while out_valid & !out_ready: src0/src1/out_valid stable, in_ready=0.
  - out_valid drops to 0 when out_ready=1 and no new transfer occurs.
- Forwarding is evaluated per operand x in {0,1} on the cycle of transfer:
  - if ex_we & ex_wa==rf_ax & rf_ax!=0, use ex_wd;
  - else if mem_we & mem_wa==rf_ax & rf_ax!=0, use mem_wd;
  - else use rf_px.
  - When both EX and MEM match, EX has priority.
- Immediate extension (result width DATA_W):
  - 00: sign-extend imm.
  - 01: zero-extend imm.
  - 10: imm in the top IMM_W bits, low bits 0.
  - 11: imm in the top IMM_W bits, low DATA_W-IMM_W bits taken from forwarded operand 1 (load-high-byte).
- Operand selection:
  - src0 = forwarded operand 0, always.
  - src1 = forwarded operand 1 if src1_sel, else the extended immediate.
- fwd_cnt:
  - On each transfer, adds the number of operands actually forwarded (0, 1 or 2).
  - Operand 1 counts only if it is used, i.e. src1_sel=1 or imm_mode=11.
  - Saturates at all-ones; no wrap.
- Flush:
  - Next cycle out_valid=0, regardless of out_ready and in_valid.
  - src0/src1 keep their old values (don't-care).
  - fwd_cnt is not incremented by a flushed transfer.
  - Flush has priority over stall and over transfer.
- Reset mid-operation: all state clears asynchronously; the first transfer after rst_n rises behaves as after power-up.

Decomposition:
- Shared package: imm_mode encodings (IMM_SEXT, IMM_ZEXT, IMM_UPPER, IMM_MERGE) and default widths DATA_W/IMM_W/REG_AW; the decoder uses the same package.
- One natural sub-module, operand_fwd_mux: combinational EX/MEM priority forwarding for one operand.
  - Instantiated twice.
  - Also outputs a "forwarded" flag used by the counter.

Test Plan:
- Reset then idle -> out_valid=0, src0=src1=0, fwd_cnt=0, in_ready=1.
- rf_p0=0x1234, src1_sel=0, imm=0x80, modes 00/01/10 across three transfers with out_ready=1 -> src1=0xFF80, 0x0080, 0x8000; src0=0x1234; one cycle latency each.
- imm_mode=11, imm=0xAB, rf_a1=3, rf_p1=0x1111, mem_we=1, mem_wa=3, mem_wd=0x00CD -> src1=0xABCD, fwd_cnt=1.
- rf_a0=5, ex_we=1 ex_wa=5 ex_wd=0xAAAA, mem_we=1 mem_wa=5 mem_wd=0xBBBB -> src0=0xAAAA (EX priority); rf_a0=0 with ex_wa=0 -> src0=rf_p0, no count.
- out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, src0/src1 stable, single transfer counted; then out_ready=1 -> next operands load.
- flush asserted with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, fwd_cnt unchanged; saturation test with fwd_cnt preloaded at 0xFFFE and two forwards -> 0xFFFF.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared widths and immediate-extension encodings for the operand stage.
// Imported by the operand stage and the decoder.
package alu_operand_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IMM_W  = 8;
  localparam int DEF_REG_AW = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'b00,
    IMM_ZEXT  = 2'b01,
    IMM_UPPER = 2'b10,
    IMM_MERGE = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// EX/MEM priority forwarding for one source operand.
// Ports: ra/rp (rf addr/data), ex_*/mem_* (writeback), op (result), fwd.
module operand_fwd_mux #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra,
  input  logic [DATA_W-1:0] rp,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_wa,
  input  logic [DATA_W-1:0] ex_wd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic [DATA_W-1:0] mem_wd,
  output logic [DATA_W-1:0] op,
  output logic              fwd
);

  logic nz, ex_hit, mem_hit;

  // r0 is hardwired zero, so a write to it is never forwarded
  assign nz      = |ra;
  assign ex_hit  = nz & ex_we & (ex_wa == ra);
  assign mem_hit = nz & mem_we & (mem_wa == ra);

  always_comb begin
    op  = rp;
    fwd = 1'b0;
    if (ex_hit) begin
      op  = ex_wd;
      fwd = 1'b1;
    end else if (mem_hit) begin
      op  = mem_wd;
      fwd = 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select with forwarding, imm extension,
// valid/ready stall/flush and a saturating forwarding-event counter.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rf_p0,
  input  logic [DATA_W-1:0] rf_p1,
  input  logic [REG_AW-1:0] rf_a0,
  input  logic [REG_AW-1:0] rf_a1,
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        imm_mode,
  input  logic              src1_sel,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_wa,
  input  logic [DATA_W-1:0] ex_wd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src0,
  output logic [DATA_W-1:0] src1,
  output logic [CNT_W-1:0]  fwd_cnt
);

  localparam int LO_W = DATA_W - IMM_W;

  logic              valid_q;
  logic [DATA_W-1:0] src0_q, src0_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] op0, op1, ext;
  logic              fwd0, fwd1, use1, xfer;
  logic [1:0]        inc;
  logic [CNT_W:0]    sum;

  operand_fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd0 (
    .ra    (rf_a0),
    .rp    (rf_p0),
    .ex_we (ex_we),
    .ex_wa (ex_wa),
    .ex_wd (ex_wd),
    .mem_we(mem_we),
    .mem_wa(mem_wa),
    .mem_wd(mem_wd),
    .op    (op0),
    .fwd   (fwd0)
  );

  operand_fwd_mux #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd1 (
    .ra    (rf_a1),
    .rp    (rf_p1),
    .ex_we (ex_we),
    .ex_wa (ex_wa),
    .ex_wd (ex_wd),
    .mem_we(mem_we),
    .mem_wa(mem_wa),
    .mem_wd(mem_wd),
    .op    (op1),
    .fwd   (fwd1)
  );

  assign in_ready = !valid_q | out_ready;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    ext = '0;
    case (imm_mode_e'(imm_mode))
      IMM_SEXT:  ext = {{LO_W{imm[IMM_W-1]}}, imm};
      IMM_ZEXT:  ext = {{LO_W{1'b0}}, imm};
      IMM_UPPER: ext = {imm, {LO_W{1'b0}}};
      IMM_MERGE: ext = {imm, op1[LO_W-1:0]};
      default:   ext = '0;
    endcase
  end

  // operand 1 is consumed by the merge mode even when imm is selected
  assign use1 = src1_sel | (imm_mode == IMM_MERGE);
  assign inc  = {1'b0, fwd0} + {1'b0, fwd1 & use1};
  assign sum  = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc};

  always_comb begin
    src0_d = op0;
    src1_d = src1_sel ? op1 : ext;
    cnt_d  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src0_q  <= '0;
      src1_q  <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      cnt_q   <= cnt_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign src0      = src0_q;
  assign src1      = src1_q;
  assign fwd_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed + random bench for alu_operand_stage.
// Transaction-level reference model, immediate assertions.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rf_p0, rf_p1;
  logic [3:0]  rf_a0, rf_a1;
  logic [7:0]  imm;
  logic [1:0]  imm_mode;
  logic        src1_sel;
  logic        ex_we, mem_we;
  logic [3:0]  ex_wa, mem_wa;
  logic [15:0] ex_wd, mem_wd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] src0, src1;
  logic [15:0] fwd_cnt;

  int total = 0;
  int bad   = 0;

  bit          m_v;
  logic [15:0] m_s0, m_s1;
  int          m_cnt;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rf_p0    (rf_p0),
    .rf_p1    (rf_p1),
    .rf_a0    (rf_a0),
    .rf_a1    (rf_a1),
    .imm      (imm),
    .imm_mode (imm_mode),
    .src1_sel (src1_sel),
    .ex_we    (ex_we),
    .ex_wa    (ex_wa),
    .ex_wd    (ex_wd),
    .mem_we   (mem_we),
    .mem_wa   (mem_wa),
    .mem_wd   (mem_wd),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .src0     (src0),
    .src1     (src1),
    .fwd_cnt  (fwd_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // value a source register really holds, given in-flight results
  function automatic int ref_val(input int a, input int p);
    if (a != 0 && ex_we && ex_wa == a) return ex_wd;
    if (a != 0 && mem_we && mem_wa == a) return mem_wd;
    return p;
  endfunction

  function automatic bit ref_hit(input int a);
    return (a != 0) && ((ex_we && ex_wa == a) || (mem_we && mem_wa == a));
  endfunction

  function automatic int ref_imm(input int op1);
    int i;
    i = imm;
    case (imm_mode)
      2'd0:    return (i >= 128) ? i + 65280 : i;
      2'd1:    return i;
      2'd2:    return i * 256;
      default: return i * 256 + (op1 % 256);
    endcase
  endfunction

  task automatic model_edge();
    int o0, o1, n;
    bit rdy;
    rdy = !m_v || out_ready;
    if (flush) begin
      m_v = 0;
    end else if (in_valid && rdy) begin
      o0 = ref_val(rf_a0, rf_p0);
      o1 = ref_val(rf_a1, rf_p1);
      m_s0 = 16'(o0);
      m_s1 = src1_sel ? 16'(o1) : 16'(ref_imm(o1));
      n = ref_hit(rf_a0) ? 1 : 0;
      if ((src1_sel || imm_mode == 2'd3) && ref_hit(rf_a1)) n++;
      m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
      m_v = 1;
    end else if (out_ready) begin
      m_v = 0;
    end
  endtask

  task automatic check_model();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_v});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_v || out_ready});
    chk("fwd_cnt", {16'd0, fwd_cnt}, m_cnt);
    if (m_v) begin
      chk("src0", {16'd0, src0}, {16'd0, m_s0});
      chk("src1", {16'd0, src1}, {16'd0, m_s1});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; rf_p0 = 0; rf_p1 = 0;
    rf_a0 = 0; rf_a1 = 0; imm = 0;
    imm_mode = 0; src1_sel = 0;
    ex_we = 0; ex_wa = 0; ex_wd = 0;
    mem_we = 0; mem_wa = 0; mem_wd = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic model_reset();
    m_v = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_src0"}, {16'd0, src0}, 32'd0);
    chk({tag, "_src1"}, {16'd0, src1}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, fwd_cnt}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic two_fwd();
    in_valid = 1; out_ready = 1; flush = 0;
    src1_sel = 1; rf_a0 = 1; rf_a1 = 2;
    ex_we = 1; ex_wa = 1; ex_wd = 16'h0101;
    mem_we = 1; mem_wa = 2; mem_wd = 16'h0202;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1;
    tick();
    chk_reset("idle");

    // immediate modes, 1-cycle latency
    rf_p0 = 16'h1234; imm = 8'h80; in_valid = 1;
    imm_mode = 2'd0; tick();
    chk("sext", {16'd0, src1}, 32'h0000FF80);
    chk("sext_s0", {16'd0, src0}, 32'h00001234);
    imm_mode = 2'd1; tick();
    chk("zext", {16'd0, src1}, 32'h00000080);
    imm_mode = 2'd2; tick();
    chk("upper", {16'd0, src1}, 32'h00008000);

    // merge with MEM-forwarded operand 1
    imm_mode = 2'd3; imm = 8'hAB;
    rf_a1 = 3; rf_p1 = 16'h1111;
    mem_we = 1; mem_wa = 3; mem_wd = 16'h00CD;
    tick();
    chk("merge", {16'd0, src1}, 32'h0000ABCD);
    chk("merge_cnt", {16'd0, fwd_cnt}, 32'd1);

    // EX beats MEM; r0 never forwarded
    idle(); in_valid = 1;
    rf_a0 = 5; rf_p0 = 16'h5555;
    ex_we = 1; ex_wa = 5; ex_wd = 16'hAAAA;
    mem_we = 1; mem_wa = 5; mem_wd = 16'hBBBB;
    tick();
    chk("ex_prio", {16'd0, src0}, 32'h0000AAAA);
    chk("ex_cnt", {16'd0, fwd_cnt}, 32'd2);
    rf_a0 = 0; ex_wa = 0; mem_wa = 0;
    tick();
    chk("r0_src0", {16'd0, src0}, 32'h00005555);
    chk("r0_cnt", {16'd0, fwd_cnt}, 32'd2);

    // drain, then stall for 3 cycles
    in_valid = 0; tick();
    in_valid = 1; out_ready = 0;
    rf_a0 = 5; ex_wa = 5; ex_wd = 16'h7777;
    tick();
    rf_p0 = 16'h9999; rf_a0 = 0;
    tick();
    tick();
    chk("stall_rdy", {31'd0, in_ready}, 32'd0);
    chk("stall_s0", {16'd0, src0}, 32'h00007777);
    chk("stall_cnt", {16'd0, fwd_cnt}, 32'd3);
    out_ready = 1;
    tick();
    chk("resume_s0", {16'd0, src0}, 32'h00009999);

    // flush with held and incoming entries
    out_ready = 0; flush = 1;
    rf_a0 = 5;
    tick();
    chk("flush_v", {31'd0, out_valid}, 32'd0);
    chk("flush_cnt", {16'd0, fwd_cnt}, 32'd3);
    flush = 0; out_ready = 1;

    // random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      rf_p0 = 16'($urandom); rf_p1 = 16'($urandom);
      rf_a0 = 4'($urandom_range(0, 3));
      rf_a1 = 4'($urandom_range(0, 3));
      imm = 8'($urandom); imm_mode = 2'($urandom);
      src1_sel = 1'($urandom);
      ex_we = 1'($urandom); mem_we = 1'($urandom);
      ex_wa = 4'($urandom_range(0, 3));
      mem_wa = 4'($urandom_range(0, 3));
      ex_wd = 16'($urandom); mem_wd = 16'($urandom);
      tick();
    end

    // asynchronous reset mid-operation
    two_fwd(); tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk_reset("midrst");
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_s0", {16'd0, src0}, 32'h00000101);
    chk("post_rst_cnt", {16'd0, fwd_cnt}, 32'd2);

    // saturation: walk counter to 0xFFFE, then overflow
    while (m_cnt < 65533) tick();
    if (m_cnt == 65533) begin
      mem_we = 0; tick();
      mem_we = 1;
    end
    chk("pre_sat", {16'd0, fwd_cnt}, 32'h0000FFFE);
    tick();
    chk("sat", {16'd0, fwd_cnt}, 32'h0000FFFF);
    tick();
    chk("sat_hold", {16'd0, fwd_cnt}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
